// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, FSM encoding and GF(2^8) constant multipliers
package aes_pkg;

    localparam int AES_NCOLS = 4;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_col_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_t;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_x2(input logic [7:0] b);
        return xt(b);
    endfunction

    function automatic logic [7:0] gf_x3(input logic [7:0] b);
        return xt(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_x9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] gf_x11(input logic [7:0] b);
        return xt(xt(xt(b)) ^ b) ^ b;
    endfunction

    function automatic logic [7:0] gf_x13(input logic [7:0] b);
        return xt(xt(xt(b) ^ b)) ^ b;
    endfunction

    function automatic logic [7:0] gf_x14(input logic [7:0] b);
        return xt(xt(xt(b) ^ b) ^ b);
    endfunction

    // Forward MixColumns on one column, row 0 in the top byte.
    function automatic aes_col_t mix_col_fwd(input aes_col_t c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_x2(a0) ^ gf_x3(a1) ^ a2 ^ a3,
                a0 ^ gf_x2(a1) ^ gf_x3(a2) ^ a3,
                a0 ^ a1 ^ gf_x2(a2) ^ gf_x3(a3),
                gf_x3(a0) ^ a1 ^ a2 ^ gf_x2(a3)};
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// inv_mix_column: combinational InvMixColumns on a single 32-bit column (row 0 in the top byte)
module inv_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = col_in;

    assign col_out = {gf_x14(a0) ^ gf_x11(a1) ^ gf_x13(a2) ^ gf_x9(a3),
                      gf_x9(a0)  ^ gf_x14(a1) ^ gf_x11(a2) ^ gf_x13(a3),
                      gf_x13(a0) ^ gf_x9(a1)  ^ gf_x14(a2) ^ gf_x11(a3),
                      gf_x11(a0) ^ gf_x13(a1) ^ gf_x9(a2)  ^ gf_x14(a3)};

endmodule

// File: rtl/inv_mix_columns.sv
// inv_mix_columns: column-serial AES InvMixColumns, one column per cycle, valid/ready on both sides.
// Define INV_MIX_COLUMNS_FWD_EN to add the encrypt port selecting forward MixColumns per block.
module inv_mix_columns
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef INV_MIX_COLUMNS_FWD_EN
    input  logic         encrypt,
`endif
    output logic [127:0] out_state
);

    fsm_t       fsm;
    logic [1:0] col;
    aes_state_t st;
    logic [6:0] msb;
    aes_col_t   cur_col, inv_col, new_col;
    logic       load;

    assign in_ready  = (fsm == IDLE) | ((fsm == DONE) & out_ready);
    assign out_valid = (fsm == DONE);
    assign out_state = st;
    assign load      = in_valid & in_ready;
    assign msb       = 7'd127 - {col, 5'b0};
    assign cur_col   = st[msb -: 32];

    inv_mix_column u_col (
        .col_in  (cur_col),
        .col_out (inv_col)
    );

`ifdef INV_MIX_COLUMNS_FWD_EN
    logic enc;

    // Direction is captured with the block so it cannot change mid-transform.
    always_ff @(posedge clk) begin
        if (rst)
            enc <= 1'b0;
        else if (load)
            enc <= encrypt;
    end

    assign new_col = enc ? mix_col_fwd(cur_col) : inv_col;
`else
    assign new_col = inv_col;
`endif

    // Load on input transfer, rewrite one column per BUSY cycle, hold in DONE until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm <= IDLE;
            col <= 2'd0;
            st  <= '0;
        end else if (load) begin
            fsm <= BUSY;
            col <= 2'd0;
            st  <= in_state;
        end else if (fsm == BUSY) begin
            st[msb -: 32] <= new_col;
            col           <= col + 2'd1;
            if (col == 2'(AES_NCOLS - 1))
                fsm <= DONE;
        end else if (fsm == DONE && out_ready) begin
            fsm <= IDLE;
        end
    end

endmodule

// File: tb/tb_inv_mix_columns.sv
// tb_inv_mix_columns: scoreboard bench with directed vectors for inv_mix_columns
module tb_inv_mix_columns;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_state;
`ifdef INV_MIX_COLUMNS_FWD_EN
    logic         encrypt = 1'b0;
`endif

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic ov_prev = 1'b0;

    localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_d5d5d7d6_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_OUT = 128'hdb135345_d4d4d4d5_01010101_c6c6c6c6;
    localparam logic [127:0] B2B_IN   = {4{32'h4d7ebdf8}};
    localparam logic [127:0] B2B_OUT  = {4{32'h2d26314c}};
    localparam logic [127:0] MIX_IN   = 128'h01010101_4d7ebdf8_c6c6c6c6_8e4da1bc;
    localparam logic [127:0] MIX_OUT  = 128'h01010101_2d26314c_c6c6c6c6_db135345;

    inv_mix_columns dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef INV_MIX_COLUMNS_FWD_EN
        .encrypt   (encrypt),
`endif
        .out_state (out_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] e, input bit expect_out);
        int n = 0;
        in_valid = 1'b1;
        in_state = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept", 128'(in_ready), 128'(1));
        if (expect_out)
            q.push_back('{data: e, due: cyc + 5});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 128'(q.size()), 128'(0));
        @(negedge clk);
    endtask

    // Monitor: latency on each rising out_valid, data on each output transfer.
    initial forever begin
        @(negedge clk);
        if (out_valid && !ov_prev) begin
            chk("result_expected", 128'(q.size() != 0), 128'(1));
            if (q.size() != 0)
                chk("latency", 128'(cyc), 128'(q[0].due));
        end
        if (out_valid && out_ready && q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("out_state", out_state, e.data);
        end
        ov_prev = out_valid;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_state", out_state, 128'h0);

        // FIPS-197 inverse vector
        @(posedge clk);
        #1;
        send(FIPS_IN, FIPS_OUT, 1'b1);
        drain();

        // Backpressure for 10 cycles after done
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(MIX_IN, MIX_OUT, 1'b1);
        begin
            int n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            chk("bp_out_state", out_state, MIX_OUT);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Back-to-back: second block held on the input while the first is busy
        @(posedge clk);
        #1;
        send(FIPS_IN, FIPS_OUT, 1'b1);
        send(B2B_IN, B2B_OUT, 1'b1);
        drain();

        // Random input traffic while busy must be ignored
        @(posedge clk);
        #1;
        send(MIX_IN, MIX_OUT, 1'b1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_state = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("busy_in_ready", 128'(in_ready), 128'(0));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        // Reset while BUSY with col==2: the block is dropped and never output
        @(posedge clk);
        #1;
        send(B2B_IN, B2B_OUT, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 128'(in_ready), 128'(1));
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        chk("abort_out_state", out_state, 128'h0);
        repeat (8) @(negedge clk);
        chk("abort_quiet", 128'(out_valid), 128'(0));

`ifdef INV_MIX_COLUMNS_FWD_EN
        // Forward direction recovers the FIPS input
        @(posedge clk);
        #1;
        encrypt = 1'b1;
        send(FIPS_OUT, FIPS_IN, 1'b1);
        encrypt = 1'b0;
        drain();
`endif

        // After reset the bench still completes a normal block
        @(posedge clk);
        #1;
        send(B2B_IN, B2B_OUT, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
